neuron_delta_gate: RTL and testbench

//  Backward-path counterpart of the hidden-layer neuron stage. Buffers the

---
 rtl/neuron_delta_gate.sv | 101 ++++++++++
 tb/tb_neuron_delta_gate.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_delta_gate.sv
// Backward-path delta gate: buffers clamped ReLU states and gates each matching
// error delta by the ReLU/clamp derivative of its paired state.
module neuron_delta_gate #(
  parameter int unsigned NC    = 4,
  parameter int unsigned WV    = 4,
  parameter int unsigned WD    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic                       iValid_AM_State1,
  output logic                       oReady_AM_State1,
  input  logic [NC*WV-1:0]           iData_AM_State1,
  input  logic                       iValid_AM_Delta0,
  output logic                       oReady_AM_Delta0,
  input  logic [NC*WD-1:0]           iData_AM_Delta0,
  output logic                       oValid_BM_Delta0,
  input  logic                       iReady_BM_Delta0,
  output logic [NC*WD-1:0]           oData_BM_Delta0,
  output logic [$clog2(DEPTH):0]     oCount
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [WV-1:0] SAT_VAL = {1'b0, {(WV-1){1'b1}}};

  logic [NC*WV-1:0] stateMem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic             outValid;
  logic [NC*WD-1:0] outData;
  logic [NC*WV-1:0] headState;
  logic [NC*WD-1:0] gated;
  logic             outFree;
  logic             push;
  logic             fire;

  assign oReady_AM_State1 = (count != CW'(DEPTH));
  assign outFree          = !outValid || iReady_BM_Delta0;
  assign oReady_AM_Delta0 = (count != '0) && outFree;
  assign push             = iValid_AM_State1 && oReady_AM_State1;
  assign fire             = iValid_AM_Delta0 && oReady_AM_Delta0;
  assign headState        = stateMem[rdPtr];

  assign oValid_BM_Delta0 = outValid;
  assign oData_BM_Delta0  = outData;
  assign oCount           = count;

  // Derivative is zero for non-positive states and for states pinned at the clamp.
  always_comb begin
    gated = '0;
    for (int i = 0; i < NC; i++) begin
      if (!(headState[i*WV + WV - 1] ||
            (headState[i*WV +: WV] == '0) ||
            (headState[i*WV +: WV] == SAT_VAL))) begin
        gated[i*WD +: WD] = iData_AM_Delta0[i*WD +: WD];
      end
    end
  end

  // Storage array carries no reset; only pointers and count define validity.
  always_ff @(posedge iCLK) begin
    if (push) begin
      stateMem[wrPtr] <= iData_AM_State1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (fire) begin
        rdPtr <= rdPtr + AW'(1);
      end
      if (push && !fire) begin
        count <= count + CW'(1);
      end else if (fire && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      outValid <= 1'b0;
      outData  <= '0;
    end else if (fire) begin
      outValid <= 1'b1;
      outData  <= gated;
    end else if (iReady_BM_Delta0) begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neuron_delta_gate.sv
// Directed self-checking bench for neuron_delta_gate (NC=2, WV=4, WD=8, DEPTH=4).
module tb_neuron_delta_gate;

  localparam int unsigned NC    = 2;
  localparam int unsigned WV    = 4;
  localparam int unsigned WD    = 8;
  localparam int unsigned DEPTH = 4;

  logic              iCLK;
  logic              iRST;
  logic              iValid_AM_State1;
  logic              oReady_AM_State1;
  logic [NC*WV-1:0]  iData_AM_State1;
  logic              iValid_AM_Delta0;
  logic              oReady_AM_Delta0;
  logic [NC*WD-1:0]  iData_AM_Delta0;
  logic              oValid_BM_Delta0;
  logic              iReady_BM_Delta0;
  logic [NC*WD-1:0]  oData_BM_Delta0;
  logic [2:0]        oCount;

  int testCount = 0;
  int failCount = 0;

  neuron_delta_gate #(.NC(NC), .WV(WV), .WD(WD), .DEPTH(DEPTH)) dut (
    .iCLK             (iCLK),
    .iRST             (iRST),
    .iValid_AM_State1 (iValid_AM_State1),
    .oReady_AM_State1 (oReady_AM_State1),
    .iData_AM_State1  (iData_AM_State1),
    .iValid_AM_Delta0 (iValid_AM_Delta0),
    .oReady_AM_Delta0 (oReady_AM_Delta0),
    .iData_AM_Delta0  (iData_AM_Delta0),
    .oValid_BM_Delta0 (oValid_BM_Delta0),
    .iReady_BM_Delta0 (iReady_BM_Delta0),
    .oData_BM_Delta0  (oData_BM_Delta0),
    .oCount           (oCount)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge iCLK);
  endtask

  // Streaming vectors: state {lane1,lane0}, delta {lane1,lane0}, hand-gated result.
  logic [7:0]  strState [8] = '{8'h18, 8'h76, 8'hF0, 8'h23, 8'h67, 8'h01, 8'h4E, 8'h55};
  logic [15:0] strDelta [8] = '{16'hAA55, 16'h0102, 16'hFF80, 16'h7F81,
                                16'h1234, 16'hC33C, 16'h9966, 16'h0FF0};
  logic [15:0] strExp   [8] = '{16'hAA00, 16'h0002, 16'h0000, 16'h7F81,
                                16'h1200, 16'h003C, 16'h9900, 16'h0FF0};
  logic [7:0]  fullState [4] = '{8'h12, 8'h34, 8'h56, 8'hF1};
  logic [15:0] fullExp   [4] = '{16'h1122, 16'h1122, 16'h1122, 16'h0022};
  logic [15:0] heldData;

  initial begin
    iRST = 1'b1;
    iValid_AM_State1 = 1'b0;
    iData_AM_State1  = '0;
    iValid_AM_Delta0 = 1'b0;
    iData_AM_Delta0  = '0;
    iReady_BM_Delta0 = 1'b1;
    tick();
    tick();
    iRST = 1'b0;
    #1;
    checkVal("rst_count", 32'(oCount), 32'd0);
    checkVal("rst_valid", 32'(oValid_BM_Delta0), 32'd0);
    checkVal("rst_data", 32'(oData_BM_Delta0), 32'd0);
    checkVal("rst_rdyState", 32'(oReady_AM_State1), 32'd1);
    checkVal("rst_rdyDelta", 32'(oReady_AM_Delta0), 32'd0);

    // Reset mid-run with two states buffered and an output pending.
    tick();
    iValid_AM_State1 = 1'b1; iData_AM_State1 = 8'h73;
    tick();
    iData_AM_State1 = 8'h05;
    tick();
    iValid_AM_State1 = 1'b0;
    checkVal("mid_count2", 32'(oCount), 32'd2);
    iReady_BM_Delta0 = 1'b0;
    iValid_AM_Delta0 = 1'b1; iData_AM_Delta0 = 16'h10F0;
    #1 checkVal("mid_rdyDelta", 32'(oReady_AM_Delta0), 32'd1);
    tick();
    iValid_AM_Delta0 = 1'b0;
    checkVal("mid_valid", 32'(oValid_BM_Delta0), 32'd1);
    checkVal("mid_count1", 32'(oCount), 32'd1);
    #2 iRST = 1'b1;
    #1;
    checkVal("arst_count", 32'(oCount), 32'd0);
    checkVal("arst_valid", 32'(oValid_BM_Delta0), 32'd0);
    checkVal("arst_data", 32'(oData_BM_Delta0), 32'd0);
    tick();
    iRST = 1'b0;
    iReady_BM_Delta0 = 1'b1;
    iValid_AM_Delta0 = 1'b1; iData_AM_Delta0 = 16'h5A5A;
    #1 checkVal("arst_rdyDelta0", 32'(oReady_AM_Delta0), 32'd0);
    tick();
    checkVal("arst_rdyDelta1", 32'(oReady_AM_Delta0), 32'd0);
    checkVal("arst_noOut", 32'(oValid_BM_Delta0), 32'd0);
    iValid_AM_Delta0 = 1'b0;

    // Gating: clamp-saturated and zero states block their lane.
    iValid_AM_State1 = 1'b1; iData_AM_State1 = 8'h73;
    tick();
    iValid_AM_State1 = 1'b0;
    iValid_AM_Delta0 = 1'b1; iData_AM_Delta0 = 16'h10F0;
    tick();
    iValid_AM_Delta0 = 1'b0;
    checkVal("gate1_valid", 32'(oValid_BM_Delta0), 32'd1);
    checkVal("gate1_data", 32'(oData_BM_Delta0), 32'h00F0);
    tick();
    checkVal("gate1_drop", 32'(oValid_BM_Delta0), 32'd0);
    checkVal("gate1_hold", 32'(oData_BM_Delta0), 32'h00F0);
    iValid_AM_State1 = 1'b1; iData_AM_State1 = 8'h05;
    tick();
    iValid_AM_State1 = 1'b0;
    iValid_AM_Delta0 = 1'b1; iData_AM_Delta0 = 16'h2233;
    tick();
    iValid_AM_Delta0 = 1'b0;
    checkVal("gate2_data", 32'(oData_BM_Delta0), 32'h0033);

    // Full: four pushes fill the FIFO, a fifth beat is refused.
    iValid_AM_State1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iData_AM_State1 = fullState[i];
      tick();
    end
    checkVal("full_count", 32'(oCount), 32'd4);
    checkVal("full_rdy", 32'(oReady_AM_State1), 32'd0);
    iData_AM_State1 = 8'h77;
    tick();
    checkVal("full_count5", 32'(oCount), 32'd4);
    iValid_AM_State1 = 1'b0;
    iValid_AM_Delta0 = 1'b1; iData_AM_Delta0 = 16'h1122;
    tick();
    iValid_AM_Delta0 = 1'b0;
    checkVal("full_rdyBack", 32'(oReady_AM_State1), 32'd1);
    checkVal("full_count3", 32'(oCount), 32'd3);
    checkVal("full_out0", 32'(oData_BM_Delta0), 32'(fullExp[0]));
    for (int i = 1; i < 4; i++) begin
      iValid_AM_Delta0 = 1'b1; iData_AM_Delta0 = 16'h1122;
      tick();
      checkVal("full_drain", 32'(oData_BM_Delta0), 32'(fullExp[i]));
    end
    iValid_AM_Delta0 = 1'b0;
    checkVal("full_empty", 32'(oCount), 32'd0);

    // Empty: delta stalls until a state arrives, no bypass.
    iValid_AM_Delta0 = 1'b1; iData_AM_Delta0 = 16'h4444;
    #1 checkVal("empty_rdy", 32'(oReady_AM_Delta0), 32'd0);
    tick();
    checkVal("empty_noOut", 32'(oValid_BM_Delta0), 32'd0);
    iValid_AM_State1 = 1'b1; iData_AM_State1 = 8'h32;
    #1 checkVal("empty_noBypass", 32'(oReady_AM_Delta0), 32'd0);
    tick();
    iValid_AM_State1 = 1'b0;
    checkVal("empty_rdyN1", 32'(oReady_AM_Delta0), 32'd1);
    checkVal("empty_validN1", 32'(oValid_BM_Delta0), 32'd0);
    tick();
    iValid_AM_Delta0 = 1'b0;
    checkVal("empty_validN2", 32'(oValid_BM_Delta0), 32'd1);
    checkVal("empty_dataN2", 32'(oData_BM_Delta0), 32'h4444);

    // Backpressure: output held for 3 cycles while a new delta waits.
    iValid_AM_State1 = 1'b1; iData_AM_State1 = 8'h21;
    tick();
    iData_AM_State1 = 8'h0C;
    tick();
    iValid_AM_State1 = 1'b0;
    iReady_BM_Delta0 = 1'b0;
    iValid_AM_Delta0 = 1'b1; iData_AM_Delta0 = 16'hABCD;
    tick();
    heldData = 16'hABCD;
    checkVal("bp_first", 32'(oData_BM_Delta0), 32'(heldData));
    iData_AM_Delta0 = 16'h6789;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkVal("bp_rdy", 32'(oReady_AM_Delta0), 32'd0);
      tick();
      checkVal("bp_data", 32'(oData_BM_Delta0), 32'(heldData));
      checkVal("bp_valid", 32'(oValid_BM_Delta0), 32'd1);
      checkVal("bp_count", 32'(oCount), 32'd1);
    end
    iReady_BM_Delta0 = 1'b1;
    #1 checkVal("bp_release", 32'(oReady_AM_Delta0), 32'd1);
    tick();
    iValid_AM_Delta0 = 1'b0;
    checkVal("bp_next", 32'(oData_BM_Delta0), 32'h0000);
    checkVal("bp_drained", 32'(oCount), 32'd0);
    tick();

    // Streaming: one state and one delta per cycle, outputs back-to-back.
    for (int k = 0; k < 10; k++) begin
      if (k >= 2) begin
        checkVal("str_valid", 32'(oValid_BM_Delta0), 32'd1);
        checkVal("str_data", 32'(oData_BM_Delta0), 32'(strExp[k-2]));
      end
      iValid_AM_State1 = (k < 8);
      iData_AM_State1  = (k < 8) ? strState[k] : 8'h00;
      iValid_AM_Delta0 = (k >= 1 && k <= 8);
      iData_AM_Delta0  = (k >= 1 && k <= 8) ? strDelta[k-1] : 16'h0000;
      #1;
      if (k >= 1 && k <= 8) checkVal("str_rdyDelta", 32'(oReady_AM_Delta0), 32'd1);
      tick();
    end
    iValid_AM_State1 = 1'b0;
    iValid_AM_Delta0 = 1'b0;
    checkVal("str_count", 32'(oCount), 32'd0);
    tick();
    checkVal("str_idle", 32'(oValid_BM_Delta0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
